// File: rtl/prf_debug_master_pkg.sv
// Shared definitions for the physical-register-file debug master.
//   SIZE_DATA / SRAM_DATA_WIDTH : word and debug-beat widths
//   DBG_BEATS                   : byte beats per word
//   DBG_IDX_W                   : width of the byte-index field on the debug address
//   dbgState_t                  : sequencer states
//   dbgRsp_t                    : response payload {rdata, err}
package prf_debug_master_pkg;

  localparam int SIZE_DATA       = 64;
  localparam int SRAM_DATA_WIDTH = 8;
  localparam int DBG_BEATS       = SIZE_DATA / SRAM_DATA_WIDTH;
  localparam int DBG_IDX_W       = 3;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    COMMIT,
    RD,
    RSP
  } dbgState_t;

  typedef struct packed {
    logic [SIZE_DATA-1:0] rdata;
    logic                 err;
  } dbgRsp_t;

endpackage

// File: rtl/prf_debug_master.sv
// Word-level initiator for the register file's byte-wide debug port.
// Takes one 64-bit read/write request, walks the eight byte beats (plus the
// commit beat for writes), reassembles read data and returns one response.
//
// Ports:
//   clk, reset      single clock, synchronous active-high reset
//   req_*           request handshake: write flag, register index, write data
//   rsp_*           response handshake: read/echoed data, out-of-range error
//   dbg_addr_o      {byte index, register index} toward the register file
//   dbg_wdata_o     write byte, latched into the file's staging word every edge
//   dbg_we_o        commit strobe, only meaningful with byte index 7
//   dbg_rdata_i     read byte, valid RD_LATENCY cycles after the address
//
// State | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a request, req_ready_o high
// WR    | byte beats 0..7 of a write, we low
// COMMIT| byte 7 again with we high, writes staging word to the register
// RD    | address beats 0..7, then RD_LATENCY drain beats at byte 7
// RSP   | response held until rsp_ready_i
module prf_debug_master
  import prf_debug_master_pkg::*;
#(
  parameter int NUM_REGS   = 128,
  parameter int REG_W      = 8,
  parameter int DATA_W     = SIZE_DATA,
  parameter int BYTE_W     = SRAM_DATA_WIDTH,
  parameter int RD_LATENCY = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic                       req_write_i,
  input  logic [REG_W-1:0]           req_reg_i,
  input  logic [DATA_W-1:0]          req_wdata_i,
  output logic                       rsp_valid_o,
  input  logic                       rsp_ready_i,
  output logic [DATA_W-1:0]          rsp_rdata_o,
  output logic                       rsp_err_o,
  output logic [REG_W+DBG_IDX_W-1:0] dbg_addr_o,
  output logic [BYTE_W-1:0]          dbg_wdata_o,
  output logic                       dbg_we_o,
  input  logic [BYTE_W-1:0]          dbg_rdata_i
);

  localparam int BEAT_W = 4;
  localparam logic [BEAT_W-1:0] LAST_WR_BEAT = BEAT_W'(DBG_BEATS - 1);
  localparam logic [BEAT_W-1:0] LAST_RD_BEAT = BEAT_W'(DBG_BEATS - 1 + RD_LATENCY);
  localparam logic [BEAT_W-1:0] RD_LAT_B     = BEAT_W'(RD_LATENCY);
  localparam logic [REG_W:0]    NUM_REGS_W   = (REG_W+1)'(NUM_REGS);

  dbgState_t                  state, stateNext;
  logic [BEAT_W-1:0]          beat, beatNext;
  logic [REG_W-1:0]           reqReg, regNext;
  logic [DATA_W-1:0]          reqData, dataNext;
  logic [DATA_W-1:0]          asmData, asmNext;
  dbgRsp_t                    rspQ, rspNext;
  logic                       reqReadyQ, reqReadyNext;
  logic                       rspValidQ, rspValidNext;
  logic [REG_W+DBG_IDX_W-1:0] dbgAddrQ, dbgAddrNext;
  logic [BYTE_W-1:0]          dbgWdataQ, dbgWdataNext;
  logic                       dbgWeQ, dbgWeNext;

  logic [BEAT_W-1:0]          capBeat;
  logic [DBG_IDX_W-1:0]       capIdx;
  logic [DBG_IDX_W-1:0]       byteIdx;

  // Read byte k arrives RD_LATENCY beats after its address beat.
  assign capBeat = beat - RD_LAT_B;
  assign capIdx  = capBeat[DBG_IDX_W-1:0];

  always_comb begin
    stateNext = state;
    beatNext  = beat;
    regNext   = reqReg;
    dataNext  = reqData;
    asmNext   = asmData;
    rspNext   = rspQ;

    case (state)
      IDLE: begin
        if (req_valid_i && reqReadyQ) begin
          regNext  = req_reg_i;
          dataNext = req_wdata_i;
          asmNext  = '0;
          beatNext = '0;
          if ({1'b0, req_reg_i} >= NUM_REGS_W) begin
            stateNext = RSP;
            rspNext   = '{rdata: '0, err: 1'b1};
          end else if (req_write_i) begin
            stateNext = WR;
          end else begin
            stateNext = RD;
          end
        end
      end
      WR: begin
        if (beat == LAST_WR_BEAT) begin
          stateNext = COMMIT;
          beatNext  = '0;
        end else begin
          beatNext = beat + 1'b1;
        end
      end
      COMMIT: begin
        stateNext = RSP;
        beatNext  = '0;
        rspNext   = '{rdata: reqData, err: 1'b0};
      end
      RD: begin
        if (beat >= RD_LAT_B) begin
          for (int k = 0; k < DBG_BEATS; k++) begin
            if (capIdx == k[DBG_IDX_W-1:0]) asmNext[k*BYTE_W +: BYTE_W] = dbg_rdata_i;
          end
        end
        if (beat == LAST_RD_BEAT) begin
          stateNext = RSP;
          beatNext  = '0;
          // Byte 7 lands on the same edge the response is launched.
          rspNext   = '{rdata: asmNext, err: 1'b0};
        end else begin
          beatNext = beat + 1'b1;
        end
      end
      RSP: begin
        if (rsp_ready_i) begin
          stateNext = IDLE;
          beatNext  = '0;
          rspNext   = '0;
        end
      end
      default: begin
        stateNext = IDLE;
        beatNext  = '0;
      end
    endcase
  end

  // Outputs are registered, so they are decoded from the next state/beat.
  always_comb begin
    reqReadyNext = (stateNext == IDLE);
    rspValidNext = (stateNext == RSP);
    dbgAddrNext  = '0;
    dbgWdataNext = '0;
    dbgWeNext    = 1'b0;
    // Drain beats past byte 7 keep the address parked on byte 7.
    byteIdx      = (beatNext > LAST_WR_BEAT) ? DBG_IDX_W'(DBG_BEATS - 1)
                                              : beatNext[DBG_IDX_W-1:0];
    case (stateNext)
      WR: begin
        dbgAddrNext = {byteIdx, regNext};
        for (int k = 0; k < DBG_BEATS; k++) begin
          if (byteIdx == k[DBG_IDX_W-1:0]) dbgWdataNext = dataNext[k*BYTE_W +: BYTE_W];
        end
      end
      COMMIT: begin
        dbgAddrNext  = {DBG_IDX_W'(DBG_BEATS - 1), regNext};
        dbgWdataNext = dataNext[DATA_W-1 -: BYTE_W];
        dbgWeNext    = 1'b1;
      end
      RD: begin
        dbgAddrNext = {byteIdx, regNext};
      end
      default: begin
        dbgAddrNext = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      beat      <= '0;
      reqReg    <= '0;
      reqData   <= '0;
      asmData   <= '0;
      rspQ      <= '0;
      reqReadyQ <= 1'b0;
      rspValidQ <= 1'b0;
      dbgAddrQ  <= '0;
      dbgWdataQ <= '0;
      dbgWeQ    <= 1'b0;
    end else begin
      state     <= stateNext;
      beat      <= beatNext;
      reqReg    <= regNext;
      reqData   <= dataNext;
      asmData   <= asmNext;
      rspQ      <= rspNext;
      reqReadyQ <= reqReadyNext;
      rspValidQ <= rspValidNext;
      dbgAddrQ  <= dbgAddrNext;
      dbgWdataQ <= dbgWdataNext;
      dbgWeQ    <= dbgWeNext;
    end
  end

  assign req_ready_o = reqReadyQ;
  assign rsp_valid_o = rspValidQ;
  assign rsp_rdata_o = rspQ.rdata;
  assign rsp_err_o   = rspQ.err;
  assign dbg_addr_o  = dbgAddrQ;
  assign dbg_wdata_o = dbgWdataQ;
  assign dbg_we_o    = dbgWeQ;

endmodule

// File: tb/tb_prf_debug_master.sv
// Bench for prf_debug_master: two instances (RD_LATENCY 1 and 2) share the
// request stimulus, each talks to its own behavioural register-file model.
module tb_prf_debug_master;

  localparam int NUM_REGS = 128;
  localparam int REG_W    = 8;

  typedef struct packed {
    logic [63:0] data;
    logic        err;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        reqValid;
  logic        reqWrite;
  logic [7:0]  reqReg;
  logic [63:0] reqWdata;
  logic        rspReady;

  logic        reqReady1, rspValid1, rspErr1, dbgWe1;
  logic [63:0] rspRdata1;
  logic [10:0] dbgAddr1;
  logic [7:0]  dbgWdata1, dbgRdata1;
  logic        reqReady2, rspValid2, rspErr2, dbgWe2;
  logic [63:0] rspRdata2;
  logic [10:0] dbgAddr2;
  logic [7:0]  dbgWdata2, dbgRdata2;

  int vectors = 0;
  int miscompares = 0;
  int weCount1 = 0;
  int weCount2 = 0;
  exp_t q1[$];
  exp_t q2[$];

  prf_debug_master #(.NUM_REGS(NUM_REGS), .REG_W(REG_W), .RD_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset),
    .req_valid_i(reqValid), .req_ready_o(reqReady1), .req_write_i(reqWrite),
    .req_reg_i(reqReg), .req_wdata_i(reqWdata),
    .rsp_valid_o(rspValid1), .rsp_ready_i(rspReady), .rsp_rdata_o(rspRdata1),
    .rsp_err_o(rspErr1), .dbg_addr_o(dbgAddr1), .dbg_wdata_o(dbgWdata1),
    .dbg_we_o(dbgWe1), .dbg_rdata_i(dbgRdata1));

  prf_debug_master #(.NUM_REGS(NUM_REGS), .REG_W(REG_W), .RD_LATENCY(2)) dut2 (
    .clk(clk), .reset(reset),
    .req_valid_i(reqValid), .req_ready_o(reqReady2), .req_write_i(reqWrite),
    .req_reg_i(reqReg), .req_wdata_i(reqWdata),
    .rsp_valid_o(rspValid2), .rsp_ready_i(rspReady), .rsp_rdata_o(rspRdata2),
    .rsp_err_o(rspErr2), .dbg_addr_o(dbgAddr2), .dbg_wdata_o(dbgWdata2),
    .dbg_we_o(dbgWe2), .dbg_rdata_i(dbgRdata2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] preload(int i);
    logic [7:0] b;
    b = i[7:0];
    return {8{b}} ^ 64'hA5A5_0000_5A5A_FFFF;
  endfunction

  // Register-file models: staging word, commit on byte 7 + we, read pipes.
  logic [63:0] mem1 [NUM_REGS];
  logic [63:0] mem2 [NUM_REGS];
  logic [63:0] stage1, stage2;
  logic [7:0]  rdPipe1, rdPipe2a, rdPipe2b;
  bit          loaded = 1'b0;
  logic [2:0]  k1, k2;
  logic [6:0]  r1, r2;
  assign k1 = dbgAddr1[10:8];
  assign r1 = dbgAddr1[6:0];
  assign k2 = dbgAddr2[10:8];
  assign r2 = dbgAddr2[6:0];
  assign dbgRdata1 = rdPipe1;
  assign dbgRdata2 = rdPipe2b;

  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem1[i] <= preload(i);
        mem2[i] <= preload(i);
      end
      stage1 <= '0;
      stage2 <= '0;
      loaded <= 1'b1;
    end else begin
      stage1[{k1, 3'b000} +: 8] <= dbgWdata1;
      stage2[{k2, 3'b000} +: 8] <= dbgWdata2;
      if (k1 == 3'd7 && dbgWe1) mem1[r1] <= {dbgWdata1, stage1[55:0]};
      if (k2 == 3'd7 && dbgWe2) mem2[r2] <= {dbgWdata2, stage2[55:0]};
      rdPipe1  <= mem1[r1][{k1, 3'b000} +: 8];
      rdPipe2a <= mem2[r2][{k2, 3'b000} +: 8];
      rdPipe2b <= rdPipe2a;
    end
  end

  always @(negedge clk) begin
    if (dbgWe1) weCount1++;
    if (dbgWe2) weCount2++;
  end

  // Drives one request at the current negedge; accepted on the next posedge (edge 0).
  task automatic issue(input logic wr, input logic [7:0] r, input logic [63:0] d);
    reqValid = 1'b1;
    reqWrite = wr;
    reqReg   = r;
    reqWdata = d;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({reqReady1, rspValid1, rspRdata1, rspErr1, dbgAddr1, dbgWdata1, dbgWe1} !== '0) begin
      miscompares++;
      $display("FAIL reset_vals1 got rdy=%b v=%b d=%h e=%b a=%h w=%h we=%b exp all 0",
               reqReady1, rspValid1, rspRdata1, rspErr1, dbgAddr1, dbgWdata1, dbgWe1);
    end
    vectors++;
    if ({reqReady2, rspValid2, rspRdata2, rspErr2, dbgAddr2, dbgWdata2, dbgWe2} !== '0) begin
      miscompares++;
      $display("FAIL reset_vals2 got rdy=%b v=%b d=%h e=%b a=%h exp all 0",
               reqReady2, rspValid2, rspRdata2, rspErr2, dbgAddr2);
    end
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if ({reqReady1, reqReady2} !== 2'b11) begin
      miscompares++;
      $display("FAIL reset_ready got %b%b exp 11", reqReady1, reqReady2);
    end
  endtask

  task automatic test_write(input logic [7:0] r, input logic [63:0] d);
    int   weStart;
    int   k;
    exp_t e;
    logic [10:0] expAddr;
    weStart = weCount1 + weCount2;
    q1.push_back('{data: d, err: 1'b0});
    q2.push_back('{data: d, err: 1'b0});
    issue(1'b1, r, d);
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      if (c == 1) reqValid = 1'b0;
      if (c <= 9) begin
        k = (c == 9) ? 7 : c - 1;
        expAddr = {k[2:0], r};
        vectors++;
        if ({dbgAddr1, dbgWdata1, dbgWe1} !== {expAddr, d[k*8 +: 8], c == 9}) begin
          miscompares++;
          $display("FAIL wr_beat1 c=%0d got a=%h w=%h we=%b exp a=%h w=%h we=%b",
                   c, dbgAddr1, dbgWdata1, dbgWe1, expAddr, d[k*8 +: 8], c == 9);
        end
        vectors++;
        if ({dbgAddr2, dbgWdata2, dbgWe2} !== {expAddr, d[k*8 +: 8], c == 9}) begin
          miscompares++;
          $display("FAIL wr_beat2 c=%0d got a=%h w=%h we=%b exp a=%h w=%h we=%b",
                   c, dbgAddr2, dbgWdata2, dbgWe2, expAddr, d[k*8 +: 8], c == 9);
        end
      end else if (c == 10) begin
        if (q1.size() > 0) e = q1.pop_front(); else e = 'x;
        vectors++;
        if ({rspValid1, rspErr1, rspRdata1} !== {1'b1, e.err, e.data}) begin
          miscompares++;
          $display("FAIL wr_rsp1 got v=%b e=%b d=%h exp v=1 e=%b d=%h",
                   rspValid1, rspErr1, rspRdata1, e.err, e.data);
        end
        if (q2.size() > 0) e = q2.pop_front(); else e = 'x;
        vectors++;
        if ({rspValid2, rspErr2, rspRdata2} !== {1'b1, e.err, e.data}) begin
          miscompares++;
          $display("FAIL wr_rsp2 got v=%b e=%b d=%h exp v=1 e=%b d=%h",
                   rspValid2, rspErr2, rspRdata2, e.err, e.data);
        end
      end else begin
        vectors++;
        if ({reqReady1, reqReady2, rspValid1, rspValid2} !== 4'b1100) begin
          miscompares++;
          $display("FAIL wr_b2b_ready got rdy=%b%b v=%b%b exp rdy=11 v=00",
                   reqReady1, reqReady2, rspValid1, rspValid2);
        end
      end
    end
    vectors++;
    if (weCount1 + weCount2 - weStart !== 2) begin
      miscompares++;
      $display("FAIL wr_we_count got %0d exp 2", weCount1 + weCount2 - weStart);
    end
  endtask

  task automatic test_read(input logic [7:0] r, input logic [63:0] d);
    int   weStart;
    exp_t e;
    weStart = weCount1 + weCount2;
    q1.push_back('{data: d, err: 1'b0});
    q2.push_back('{data: d, err: 1'b0});
    issue(1'b0, r, 64'hDEAD_BEEF_DEAD_BEEF);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) reqValid = 1'b0;
      if (c <= 8) begin
        vectors++;
        if ({dbgAddr1, dbgAddr2, rspValid1} !== {3'(c - 1), r, 3'(c - 1), r, 1'b0}) begin
          miscompares++;
          $display("FAIL rd_addr c=%0d got a1=%h a2=%h v=%b exp a=%h", c, dbgAddr1, dbgAddr2,
                   rspValid1, {3'(c - 1), r});
        end
      end else if (c == 9) begin
        vectors++;
        if ({dbgAddr1, dbgAddr2, rspValid1, rspValid2} !== {3'd7, r, 3'd7, r, 2'b00}) begin
          miscompares++;
          $display("FAIL rd_drain got a1=%h a2=%h v=%b%b exp a=%h v=00",
                   dbgAddr1, dbgAddr2, rspValid1, rspValid2, {3'd7, r});
        end
      end else if (c == 10) begin
        if (q1.size() > 0) e = q1.pop_front(); else e = 'x;
        vectors++;
        if ({rspValid1, rspErr1, rspRdata1} !== {1'b1, e.err, e.data}) begin
          miscompares++;
          $display("FAIL rd_rsp1 got v=%b e=%b d=%h exp v=1 e=%b d=%h",
                   rspValid1, rspErr1, rspRdata1, e.err, e.data);
        end
        vectors++;
        if ({rspValid2, dbgAddr2} !== {1'b0, 3'd7, r}) begin
          miscompares++;
          $display("FAIL rd_lat2_drain got v=%b a=%h exp v=0 a=%h", rspValid2, dbgAddr2, {3'd7, r});
        end
      end else if (c == 11) begin
        if (q2.size() > 0) e = q2.pop_front(); else e = 'x;
        vectors++;
        if ({rspValid2, rspErr2, rspRdata2} !== {1'b1, e.err, e.data}) begin
          miscompares++;
          $display("FAIL rd_rsp2 got v=%b e=%b d=%h exp v=1 e=%b d=%h",
                   rspValid2, rspErr2, rspRdata2, e.err, e.data);
        end
        vectors++;
        if ({reqReady1, rspValid1, dbgAddr1} !== {2'b10, 11'd0}) begin
          miscompares++;
          $display("FAIL rd_idle1 got rdy=%b v=%b a=%h exp rdy=1 v=0 a=0", reqReady1, rspValid1, dbgAddr1);
        end
      end else begin
        vectors++;
        if ({reqReady1, reqReady2} !== 2'b11) begin
          miscompares++;
          $display("FAIL rd_ready got %b%b exp 11", reqReady1, reqReady2);
        end
      end
    end
    vectors++;
    if (weCount1 + weCount2 !== weStart) begin
      miscompares++;
      $display("FAIL rd_no_we got %0d exp %0d", weCount1 + weCount2, weStart);
    end
  endtask

  task automatic test_error(input logic [7:0] r);
    exp_t e;
    q1.push_back('{data: '0, err: 1'b1});
    q2.push_back('{data: '0, err: 1'b1});
    issue(1'b1, r, 64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge clk);
    reqValid = 1'b0;
    if (q1.size() > 0) e = q1.pop_front(); else e = 'x;
    vectors++;
    if ({rspValid1, rspErr1, rspRdata1, dbgAddr1, dbgWdata1, dbgWe1} !== {1'b1, e.err, e.data, 20'd0}) begin
      miscompares++;
      $display("FAIL err_rsp1 got v=%b e=%b d=%h a=%h w=%h we=%b exp v=1 e=1 d=0 dbg=0",
               rspValid1, rspErr1, rspRdata1, dbgAddr1, dbgWdata1, dbgWe1);
    end
    if (q2.size() > 0) e = q2.pop_front(); else e = 'x;
    vectors++;
    if ({rspValid2, rspErr2, rspRdata2, dbgAddr2, dbgWdata2, dbgWe2} !== {1'b1, e.err, e.data, 20'd0}) begin
      miscompares++;
      $display("FAIL err_rsp2 got v=%b e=%b d=%h a=%h exp v=1 e=1 d=0 dbg=0",
               rspValid2, rspErr2, rspRdata2, dbgAddr2);
    end
    @(negedge clk);
    vectors++;
    if ({reqReady1, reqReady2, dbgAddr1, dbgAddr2} !== {2'b11, 22'd0}) begin
      miscompares++;
      $display("FAIL err_after got rdy=%b%b a1=%h a2=%h exp rdy=11 a=0", reqReady1, reqReady2, dbgAddr1, dbgAddr2);
    end
  endtask

  task automatic test_backpressure(input logic [7:0] r, input logic [63:0] d);
    exp_t e1, e2;
    q1.push_back('{data: d, err: 1'b0});
    q2.push_back('{data: d, err: 1'b0});
    rspReady = 1'b0;
    issue(1'b0, r, '0);
    @(negedge clk);
    reqValid = 1'b0;
    repeat (10) @(negedge clk);
    if (q1.size() > 0) e1 = q1.pop_front(); else e1 = 'x;
    if (q2.size() > 0) e2 = q2.pop_front(); else e2 = 'x;
    for (int c = 0; c < 20; c++) begin
      vectors++;
      if ({rspValid1, rspErr1, rspRdata1, reqReady1} !== {1'b1, e1.err, e1.data, 1'b0} ||
          {rspValid2, rspErr2, rspRdata2, reqReady2} !== {1'b1, e2.err, e2.data, 1'b0}) begin
        miscompares++;
        $display("FAIL bp_hold c=%0d got v=%b%b d1=%h d2=%h rdy=%b%b exp v=11 d=%h rdy=00",
                 c, rspValid1, rspValid2, rspRdata1, rspRdata2, reqReady1, reqReady2, d);
      end
      @(negedge clk);
    end
    rspReady = 1'b1;
    @(negedge clk);
    vectors++;
    if ({rspValid1, rspValid2, reqReady1, reqReady2} !== 4'b0011) begin
      miscompares++;
      $display("FAIL bp_release got v=%b%b rdy=%b%b exp v=00 rdy=11", rspValid1, rspValid2, reqReady1, reqReady2);
    end
  endtask

  task automatic test_reset_midwrite();
    int weStart;
    weStart = weCount1 + weCount2;
    issue(1'b1, 8'd3, 64'hFFFF_FFFF_FFFF_FFFF);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) reqValid = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if ({reqReady1, rspValid1, rspRdata1, rspErr1, dbgAddr1, dbgWdata1, dbgWe1,
         reqReady2, rspValid2, rspRdata2, rspErr2, dbgAddr2, dbgWdata2, dbgWe2} !== '0) begin
      miscompares++;
      $display("FAIL midrst_vals got a1=%h we1=%b a2=%h we2=%b rdy=%b%b exp all 0",
               dbgAddr1, dbgWe1, dbgAddr2, dbgWe2, reqReady1, reqReady2);
    end
    reset = 1'b0;
    @(negedge clk);
    vectors++;
    if ({reqReady1, reqReady2} !== 2'b11) begin
      miscompares++;
      $display("FAIL midrst_ready got %b%b exp 11", reqReady1, reqReady2);
    end
    vectors++;
    if (weCount1 + weCount2 !== weStart) begin
      miscompares++;
      $display("FAIL midrst_no_we got %0d exp %0d", weCount1 + weCount2, weStart);
    end
    test_read(8'd3, preload(3));
  endtask

  initial begin
    logic [7:0]  r;
    logic [63:0] d;
    reset    = 1'b1;
    reqValid = 1'b0;
    reqWrite = 1'b0;
    reqReg   = '0;
    reqWdata = '0;
    rspReady = 1'b1;
    test_reset();
    test_write(8'd5, 64'h0123_4567_89AB_CDEF);
    test_read(8'd5, 64'h0123_4567_89AB_CDEF);
    test_read(8'd127, preload(127));
    test_error(8'd128);
    test_error(8'd255);
    for (int i = 0; i < 3; i++) begin
      r = 8'($urandom_range(8, 126));
      d = {$urandom, $urandom};
      test_write(r, d);
      test_read(r, d);
    end
    test_backpressure(8'd5, 64'h0123_4567_89AB_CDEF);
    test_reset_midwrite();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
